// File: rtl/uart_recv.sv
`default_nettype none
// ============================================================================
// Module   : uart_recv
// Purpose  : 8N1 UART receiver with mid-bit sampling, 2-flop input
//            synchronizer and one-cycle data/frame-error pulses.
//            Optional stop-bit checking: define UART_RECV_FRAME_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_recv #(
    parameter int CLK  = 50000000,
    parameter int BAUD = 115200
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       UART_rx,
    output logic [7:0] data_out,
    output logic       flag_out,
    output logic       frame_err,
    output logic       busy
);

    localparam int c_bit_cnt  = CLK / BAUD;
    localparam int c_half_cnt = c_bit_cnt / 2;
    localparam int c_cw       = $clog2(c_bit_cnt);
    localparam logic [c_cw-1:0] c_bit_last  = c_cw'(c_bit_cnt - 1);
    localparam logic [c_cw-1:0] c_half_last = c_cw'(c_half_cnt - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [c_cw-1:0]   r_cnt, w_cnt_nxt;
    logic [2:0]        r_idx, w_idx_nxt;
    logic [7:0]        r_shift, w_shift_nxt;
    logic [7:0]        r_data, w_data_nxt;
    logic              r_flag, w_flag_nxt;
    logic              r_sync1, r_sync2, r_prev;
    logic              w_fall;

    assign w_fall   = r_prev & ~r_sync2;
    assign data_out = r_data;
    assign flag_out = r_flag;
    assign busy     = (r_state != S_IDLE);

`ifdef UART_RECV_FRAME_CHECK_EN
    logic r_ferr, w_ferr_nxt;
    assign frame_err = r_ferr;
`else
    assign frame_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= 8'h00;
            r_flag  <= 1'b0;
`ifdef UART_RECV_FRAME_CHECK_EN
            r_ferr  <= 1'b0;
`endif
        end else begin
            r_sync1 <= UART_rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_flag  <= w_flag_nxt;
`ifdef UART_RECV_FRAME_CHECK_EN
            r_ferr  <= w_ferr_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_flag_nxt  = 1'b0;
`ifdef UART_RECV_FRAME_CHECK_EN
        w_ferr_nxt  = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = '0;
                end
            end
            S_START: begin
                if (r_cnt == c_half_last) begin
                    w_cnt_nxt = '0;
                    w_idx_nxt = '0;
                    // A line already back high at mid-start is a glitch
                    w_state_nxt = r_sync2 ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (r_cnt == c_bit_last) begin
                    w_cnt_nxt            = '0;
                    w_shift_nxt[r_idx]   = r_sync2;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_STOP: begin
                // Returning to IDLE at mid-stop re-arms for a gapless next start
                if (r_cnt == c_bit_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
`ifdef UART_RECV_FRAME_CHECK_EN
                    if (r_sync2) begin
                        w_data_nxt = r_shift;
                        w_flag_nxt = 1'b1;
                    end else begin
                        w_ferr_nxt = 1'b1;
                    end
`else
                    w_data_nxt = r_shift;
                    w_flag_nxt = 1'b1;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_recv.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_recv
// Purpose  : Directed self-checking bench for uart_recv at default CLK/BAUD.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_recv;

    localparam int BIT = 50000000 / 115200;

    logic       clk;
    logic       rstn;
    logic       UART_rx;
    logic [7:0] data_out;
    logic       flag_out;
    logic       frame_err;
    logic       busy;

    uart_recv #(.CLK(50000000), .BAUD(115200)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .UART_rx   (UART_rx),
        .data_out  (data_out),
        .flag_out  (flag_out),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int       n_total = 0;
    int       n_pass  = 0;
    int       n_flag  = 0;
    int       n_ferr  = 0;
    logic     bad_overlap = 1'b0;
    logic     bad_busy    = 1'b0;
    logic     bad_width   = 1'b0;
    logic     prev_flag   = 1'b0;
    logic [7:0] rx_q[$];

    // Pulse monitor, sampled on the falling edge
    always @(negedge clk) begin
        prev_flag <= flag_out;
        if (flag_out) begin
            n_flag <= n_flag + 1;
            rx_q.push_back(data_out);
            if (busy)      bad_busy  <= 1'b1;
            if (prev_flag) bad_width <= 1'b1;
        end
        if (frame_err)             n_ferr      <= n_ferr + 1;
        if (flag_out && frame_err) bad_overlap <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        UART_rx = b;
        wait_clks(BIT);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    logic [7:0] hello [9];
    int base_f, base_e, base_q;

    initial begin
        hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h31, 8'h32, 8'h33, 8'h0A};
        rstn    = 1'b0;
        UART_rx = 1'b1;
        wait_clks(3);
        check("rst_data",  {24'h0, data_out}, 32'h00);
        check("rst_flag",  {31'h0, flag_out}, 32'h0);
        check("rst_ferr",  {31'h0, frame_err}, 32'h0);
        check("rst_busy",  {31'h0, busy}, 32'h0);
        rstn = 1'b1;
        wait_clks(BIT);

        // Single 'H'
        base_f = n_flag; base_e = n_ferr;
        send_frame(8'h48, 1'b1);
        wait_clks(5);
        check("h_flags", n_flag - base_f, 1);
        check("h_data",  {24'h0, data_out}, 32'h48);
        check("h_ferr",  n_ferr - base_e, 0);
        check("h_busy",  {31'h0, busy}, 32'h0);

        // Back-to-back string, no idle gap
        base_f = n_flag; base_q = rx_q.size();
        for (int k = 0; k < 9; k++) send_frame(hello[k], 1'b1);
        wait_clks(5);
        check("str_flags", n_flag - base_f, 9);
        for (int k = 0; k < 9; k++)
            check($sformatf("str_byte%0d", k),
                  (base_q + k < rx_q.size()) ? {24'h0, rx_q[base_q + k]} : 32'hFFFF_FFFF,
                  {24'h0, hello[k]});

        // 100-clock low glitch on idle line
        base_f = n_flag;
        UART_rx = 1'b0;
        wait_clks(50);
        check("gl_busy_hi", {31'h0, busy}, 32'h1);
        wait_clks(50);
        UART_rx = 1'b1;
        wait_clks(140);
        check("gl_busy_lo", {31'h0, busy}, 32'h0);
        check("gl_flags",   n_flag - base_f, 0);
        check("gl_data",    {24'h0, data_out}, 32'h0A);
        wait_clks(BIT);

        // 0xA5 with a bad stop bit
        base_f = n_flag; base_e = n_ferr;
        send_frame(8'hA5, 1'b0);
        UART_rx = 1'b1;
        wait_clks(5);
`ifdef UART_RECV_FRAME_CHECK_EN
        check("bs_ferr",  n_ferr - base_e, 1);
        check("bs_flags", n_flag - base_f, 0);
        check("bs_data",  {24'h0, data_out}, 32'h0A);
`else
        check("bs_ferr",  n_ferr - base_e, 0);
        check("bs_flags", n_flag - base_f, 1);
        check("bs_data",  {24'h0, data_out}, 32'hA5);
`endif
        wait_clks(BIT);

        // Reset during bit 4 of 0x3C
        base_f = n_flag;
        send_bit(1'b0);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        UART_rx = 1'b1;
        wait_clks(200);
        rstn = 1'b0;
        wait_clks(5);
        check("ra_busy", {31'h0, busy}, 32'h0);
        check("ra_data", {24'h0, data_out}, 32'h00);
        rstn = 1'b1;
        wait_clks(2 * BIT);
        check("ra_flags", n_flag - base_f, 0);
        send_frame(8'h5A, 1'b1);
        wait_clks(5);
        check("ra_flags2", n_flag - base_f, 1);
        check("ra_data2",  {24'h0, data_out}, 32'h5A);

        // Break: 20 bit times low, then high, then 0x01
        base_f = n_flag; base_e = n_ferr;
        UART_rx = 1'b0;
        wait_clks(20 * BIT);
        UART_rx = 1'b1;
        wait_clks(2 * BIT);
        send_frame(8'h01, 1'b1);
        wait_clks(5);
`ifdef UART_RECV_FRAME_CHECK_EN
        check("brk_ferr",  n_ferr - base_e, 1);
        check("brk_flags", n_flag - base_f, 1);
`else
        check("brk_ferr",  n_ferr - base_e, 0);
        check("brk_flags", n_flag - base_f, 2);
`endif
        check("brk_data", {24'h0, data_out}, 32'h01);

        check("flag_ferr_overlap", {31'h0, bad_overlap}, 32'h0);
        check("busy_in_pulse",     {31'h0, bad_busy}, 32'h0);
        check("flag_width",        {31'h0, bad_width}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_recv.md
UART_RECV -- requirements
Module: uart_recv

Interface
REQ-001 Parameter CLK, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line rate in bit/s; BIT_CNT = CLK/BAUD (integer division, 434 at defaults), HALF_CNT = BIT_CNT/2 (217).
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 rstn  input  1  asynchronous active-low reset.
REQ-005 UART_rx  input  1  asynchronous serial line, 8N1, LSB first, idle high.
REQ-006 data_out  output  8  last correctly received byte, held until next good byte.
REQ-007 flag_out  output  1  one-cycle pulse: data_out just updated; same convention as the transmitter's flag_in, so it can drive it directly for loopback.
REQ-008 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 busy  output  1  high in any state other than IDLE.

Function
REQ-010 UART_rx SHALL pass through a 2-flop synchronizer; a third flop holds the previous synchronized value for edge detection.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP; one baud counter (width ceil(log2(BIT_CNT)), ≥9 bits at defaults) and a 3-bit bit index.
REQ-012 IDLE: on synchronized falling edge (prev=1, now=0) go to START, counter cleared.
REQ-013 START: at counter == HALF_CNT-1 sample line; if 0 go to DATA with counter and bit index cleared; if 1 (glitch) return to IDLE, no output activity.
REQ-014 DATA: at counter == BIT_CNT-1 sample into shift register bit[index], clear counter; after index 7 go to STOP; otherwise index+1.
REQ-015 STOP: at counter == BIT_CNT-1 sample stop bit, then go to IDLE in the same edge.
REQ-016 Good stop (1): data_out loaded and flag_out high for exactly the one cycle after the stop sample edge.
REQ-017 Bad stop (0): behaviour per REQ-024/025.
REQ-018 Because IDLE requires a high-to-low transition, a line held low (break) SHALL NOT start a new frame until it returns high.
REQ-019 Back-to-back frames with no idle gap between stop and next start SHALL all be received; re-arming at mid-stop guarantees this.
REQ-020 flag_out and frame_err SHALL never be high in the same cycle.

Reset
REQ-021 rstn low SHALL asynchronously force: state IDLE, counters 0, data_out 8'h00, flag_out 0, frame_err 0, busy 0, all synchronizer/edge flops 1.
REQ-022 Reset mid-frame SHALL abandon the frame with no flag_out; after release, reception restarts only on a fresh falling edge.

Configuration
REQ-023 Macro UART_RECV_FRAME_CHECK_EN selects stop-bit checking.
REQ-024 Defined: bad stop bit pulses frame_err one cycle, data_out unchanged, no flag_out.
REQ-025 Undefined: stop bit not checked, every frame loads data_out and pulses flag_out; frame_err tied 0; port list identical in both builds.

Verification (defaults CLK=50000000, BAUD=115200, bit = 434 clocks)
REQ-026 Send 8'h48 ('H') 8N1 -> one flag_out pulse, data_out=8'h48, frame_err stays 0, busy falls with the pulse.
REQ-027 Send "HELLO123\n" back-to-back, zero idle bits -> nine flag_out pulses, bytes 48 45 4C 4C 4F 31 32 33 0A in order.
REQ-028 Low glitch of 100 clocks on idle line -> busy high then low before clock 217, no flag_out, data_out unchanged.
REQ-029 Send 8'hA5 with stop bit 0: with macro -> frame_err pulse, no flag_out, data_out keeps prior value; without macro -> flag_out pulse, data_out=8'hA5.
REQ-030 Assert rstn during bit 4 of 8'h3C, release, then send 8'h5A -> no pulse for the aborted frame, data_out=8'h5A after second frame.
REQ-031 Hold line low 20 bit times then high, then send 8'h01 -> at most one frame_err (macro on) for the break, then data_out=8'h01 with one flag_out.
